// File: rtl/escalator_ctrl_if.sv
// Landing-sensor, timer-tick and motor-drive signals of the escalator controller.
// The master modport is the controller; the slave modport is its environment.
interface escalator_ctrl_if;
    localparam int unsigned STATE_W = 3;

    logic               sensor_bottom;
    logic               sensor_top;
    logic               one_sec_timer;
    logic               five_sec_timer;
    logic               reset_timer;
    logic               motor_up;
    logic               motor_down;
    logic               motor_slow;
    logic               buzzer;
    logic [STATE_W-1:0] state_o;

    modport master (
        input  sensor_bottom, sensor_top, one_sec_timer, five_sec_timer,
        output reset_timer, motor_up, motor_down, motor_slow, buzzer, state_o
    );

    modport slave (
        output sensor_bottom, sensor_top, one_sec_timer, five_sec_timer,
        input  reset_timer, motor_up, motor_down, motor_slow, buzzer, state_o
    );
endinterface

// File: rtl/escalator_ctrl.sv
// Escalator run/stop/direction FSM consuming one/five-second timer ticks.
// Define ESC_SLOW_EN to add the reduced-speed SLOW state.
module escalator_ctrl #(
    parameter int unsigned IDLE_PERIODS = 3,
    parameter int unsigned DWELL_SECS   = 2
`ifdef ESC_SLOW_EN
    ,
    parameter int unsigned SLOW_PERIODS = 1
`endif
) (
    input  logic             clk_50m,
    input  logic             reset,
    escalator_ctrl_if.master bus
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ST_W  = 3;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(15);
    localparam logic [CNT_W-1:0] IDLE_LIM  = CNT_W'(IDLE_PERIODS);
    localparam logic [CNT_W-1:0] DWELL_LIM = CNT_W'(DWELL_SECS);
`ifdef ESC_SLOW_EN
    localparam logic [CNT_W-1:0] SLOW_LIM  = CNT_W'(SLOW_PERIODS);
`endif

    typedef enum logic [ST_W-1:0] {
        S_IDLE = 3'd0,
        S_WARN = 3'd1,
        S_RUN  = 3'd2,
        S_STOP = 3'd3
`ifdef ESC_SLOW_EN
        ,
        S_SLOW = 3'd4
`endif
    } state_t;

    state_t           state, state_n;
    logic             dir_up, dir_up_n;
    logic             pend, pend_n;
    logic [CNT_W-1:0] idle_cnt, idle_n;
    logic [CNT_W-1:0] sec_cnt, sec_n;
    logic             restart;
    logic             entry, opposite;
    logic             reset_timer_q, reset_timer_n;
    logic             motor_up_q, motor_up_n;
    logic             motor_down_q, motor_down_n;
    logic             buzzer_q, buzzer_n;
`ifdef ESC_SLOW_EN
    logic             motor_slow_q, motor_slow_n;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Next state, counters and registered-output values.
    always_comb begin
        state_n  = state;
        dir_up_n = dir_up;
        pend_n   = pend;
        idle_n   = '0;
        sec_n    = '0;
        restart  = 1'b0;
        entry    = dir_up ? bus.sensor_bottom : bus.sensor_top;
        opposite = dir_up ? bus.sensor_top : bus.sensor_bottom;

        case (state)
            S_IDLE: begin
                if (bus.sensor_bottom) begin
                    state_n  = S_WARN;
                    dir_up_n = 1'b1;
                end else if (bus.sensor_top) begin
                    state_n  = S_WARN;
                    dir_up_n = 1'b0;
                end
            end
            S_WARN: begin
                if (bus.one_sec_timer) begin
                    state_n = S_RUN;
                    restart = 1'b1;
                end
            end
            S_RUN: begin
                idle_n = idle_cnt;
                if (opposite) pend_n = 1'b1;
                if (entry) begin
                    idle_n  = '0;
                    restart = 1'b1;
                end else begin
                    if (bus.five_sec_timer) idle_n = sat_inc(idle_cnt);
                    if (idle_cnt == IDLE_LIM) begin
                        state_n = S_STOP;
                        restart = 1'b1;
                    end
`ifdef ESC_SLOW_EN
                    else if (idle_cnt == SLOW_LIM) begin
                        state_n = S_SLOW;
                    end
`endif
                end
            end
`ifdef ESC_SLOW_EN
            S_SLOW: begin
                idle_n = idle_cnt;
                if (opposite) pend_n = 1'b1;
                if (entry) begin
                    state_n = S_RUN;
                    idle_n  = '0;
                    restart = 1'b1;
                end else begin
                    if (bus.five_sec_timer) idle_n = sat_inc(idle_cnt);
                    if (idle_cnt == IDLE_LIM) begin
                        state_n = S_STOP;
                        restart = 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                sec_n = sec_cnt;
                if (opposite) pend_n = 1'b1;
                if (bus.one_sec_timer) sec_n = sat_inc(sec_cnt);
                // Dwell done: reverse only if someone waited at the far end
                if (sec_cnt == DWELL_LIM) begin
                    pend_n = 1'b0;
                    if (pend) begin
                        state_n  = S_WARN;
                        dir_up_n = ~dir_up;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Output decode from the state being entered.
    always_comb begin
        reset_timer_n = 1'b1;
        motor_up_n    = 1'b0;
        motor_down_n  = 1'b0;
        buzzer_n      = 1'b0;
`ifdef ESC_SLOW_EN
        motor_slow_n  = 1'b0;
`endif
        case (state_n)
            S_IDLE: reset_timer_n = 1'b0;
            S_WARN: buzzer_n = 1'b1;
            S_RUN: begin
                motor_up_n    = dir_up_n;
                motor_down_n  = ~dir_up_n;
                reset_timer_n = ~restart;
            end
`ifdef ESC_SLOW_EN
            S_SLOW: begin
                motor_up_n   = dir_up_n;
                motor_down_n = ~dir_up_n;
                motor_slow_n = 1'b1;
            end
`endif
            S_STOP:  reset_timer_n = ~restart;
            default: reset_timer_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            state         <= S_IDLE;
            dir_up        <= 1'b1;
            pend          <= 1'b0;
            idle_cnt      <= '0;
            sec_cnt       <= '0;
            reset_timer_q <= 1'b0;
            motor_up_q    <= 1'b0;
            motor_down_q  <= 1'b0;
            buzzer_q      <= 1'b0;
`ifdef ESC_SLOW_EN
            motor_slow_q  <= 1'b0;
`endif
        end else begin
            state         <= state_n;
            dir_up        <= dir_up_n;
            pend          <= pend_n;
            idle_cnt      <= idle_n;
            sec_cnt       <= sec_n;
            reset_timer_q <= reset_timer_n;
            motor_up_q    <= motor_up_n;
            motor_down_q  <= motor_down_n;
            buzzer_q      <= buzzer_n;
`ifdef ESC_SLOW_EN
            motor_slow_q  <= motor_slow_n;
`endif
        end
    end

    assign bus.reset_timer = reset_timer_q;
    assign bus.motor_up    = motor_up_q;
    assign bus.motor_down  = motor_down_q;
    assign bus.buzzer      = buzzer_q;
    assign bus.state_o     = state;
`ifdef ESC_SLOW_EN
    assign bus.motor_slow  = motor_slow_q;
`else
    assign bus.motor_slow  = 1'b0;
`endif
endmodule
